joystick_frontend: RTL and testbench
====================================

// Module: joystick_frontend
// PURPOSE
//  Conditioning stage directly upstream of the PC game-port joystick block.
//  - Registers raw HPS pad words on an update strobe.
//  - Applies an analog deadzone and clamp.
//  - Generates the Gravis GamePad Pro serial clock (clk_grav).
//  - In mode 2, changes dig_* only inside the serial-frame header so the consumer never shifts a torn frame.
// PARAMETERS
//  CLK_HZ    90500000  system clock frequency
//  GRAV_HZ   20000     clk_grav frequency; HALF = CLK_HZ/(2*GRAV_HZ) = 2262 at defaults
//  DEADZONE  8         |axis| <= DEADZONE is forced to 0 (0 disables)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset; shared with the consumer's reset
//  joy_stb    in   1   one-cycle strobe: joy_dig_*/joy_ana_* valid
//  joy_dig_1  in   14  raw pad 1 {L2,R2,L1,R1,SEL,START,B4..B1,UP,DOWN,LEFT,RIGHT}, 1 = pressed
//  joy_dig_2  in   14  raw pad 2, same layout
//  joy_ana_1  in   16  raw pad 1 {Y[7:0],X[7:0]}, signed
//  joy_ana_2  in   16  raw pad 2, same layout
//  mode       in   2   0 = 2x 2-button, 1 = 1x 4-button, 2 = Gravis serial, 3 = as 0
//  dig_1      out  14  conditioned pad 1 digital
//  dig_2      out  14  conditioned pad 2 digital
//  ana_1      out  16  conditioned pad 1 analog
//  ana_2      out  16  conditioned pad 2 analog
//  clk_grav   out  1   Gravis serial clock, 50% duty
// BEHAVIOUR
//  Reset
//  - dig_*, ana_*, holding regs = 0; clk_grav = 0; half-period counter = 0; grav_pos = 0.
//  - Reset may arrive mid-frame; the consumer resets with the same reset, so both restart at frame position 0.
//  Capture
//  - On joy_stb, the raw inputs are latched into hold regs (hold_dig_*, hold_ana_*) at the next clk edge.
//  - Without joy_stb, the hold regs keep their value.
//  Analog path (per axis, 8-bit two's complement)
//  - -128 is clamped to -127.
//  - If |v| <= DEADZONE, then v = 0; otherwise v passes unchanged.
//  - ana_* = conditioned hold value, registered: 1 clk after the hold regs update (2 clks after joy_stb).
//  - Applies in every mode.
//  Digital path, mode != 2
//  - dig_* = hold_dig_*, registered: 2 clks after joy_stb.
//  Gravis clock
//  - hcnt counts 0..HALF-1 while mode==2 or clk_grav==1.
//  - At HALF-1: hcnt = 0 and clk_grav toggles.
//  - On every 0->1 toggle, grav_pos = (grav_pos==23) ? 0 : grav_pos+1 (mirrors the consumer's frame position).
//  - Leaving mode 2 mid-high: the high phase completes, then clk_grav is held 0 and hcnt = 0.
//  - grav_pos is retained (never cleared except by rst) so the two sides stay in lockstep on re-entry.
//  - Entering mode 2: the first rising edge occurs HALF clks later.
//  Digital path, mode == 2 (tear-free)
//  - dig_* load from hold_dig_* only on the 1->0 toggle of clk_grav while grav_pos==1.
//  - That point is inside the header, so the data bits of any frame come from a single snapshot.
//  - If joy_stb coincides with that toggle cycle, the old hold value is loaded; the new value waits one frame.
//  - Worst-case digital latency: 24 clk_grav periods + 2 clks.
//  Mode change 2 -> other: dig_* follow hold_dig_* from the next cycle.
//  Arithmetic
//  - HALF is computed at elaboration.
//  - hcnt width = $clog2(HALF); grav_pos is 5 bits.
// STRUCTURE
//  Package joystick_pkg:
//  - dig bit-index localparams (JB_RIGHT=0 .. JB_L2=13)
//  - MODE_2BTN/MODE_4BTN/MODE_GRAVIS encodings
//  - GRAV_FRAME_LEN=24
//  Sub-module joystick_axis_cond: one 8-bit clamp+deadzone, combinational; instanced x4.
//  Top: capture regs, gravis divider/position counter, output regs.
// TESTING
//  1 rst, mode=0, joy_stb with joy_dig_1=14'h0010 -> dig_1=14'h0010 exactly 2 clks after stb; clk_grav stays 0.
//  2 joy_ana_1=16'h80_05, DEADZONE=8 -> ana_1=16'h81_00; joy_ana_1=16'h09_F7 -> ana_1=16'h09_F7.
//  3 mode=2, HALF=2262 -> clk_grav period 4524 clks, high 2262;
//    grav_pos wraps 23->0 on the 24th rise; check against a consumer model's frame position.
//  4 mode=2, joy_stb with new dig at grav_pos=12 -> dig_1 unchanged until the 1->0 edge at grav_pos==1;
//    the consumer model decodes no mixed frame.
//  5 mode 2->0 while clk_grav=1 -> high phase completes (total 2262 clks), then 0 forever;
//    back to 2 -> next rise after 2262 clks, grav_pos continues from its retained value.
//  6 rst asserted mid-frame (grav_pos=15) -> next cycle all outputs 0, grav_pos=0;
//    first rise 2262 clks after rst deasserts.

Source files
------------

// File: rtl/joystick_pkg.sv
// Shared definitions for the game-port joystick front end: button bit layout,
// mode encodings and the Gravis serial frame length.
package joystick_pkg;

  localparam int JOY_DIG_W = 14;
  localparam int JOY_ANA_W = 16;

  localparam int JB_RIGHT = 0;
  localparam int JB_LEFT  = 1;
  localparam int JB_DOWN  = 2;
  localparam int JB_UP    = 3;
  localparam int JB_B1    = 4;
  localparam int JB_B2    = 5;
  localparam int JB_B3    = 6;
  localparam int JB_B4    = 7;
  localparam int JB_START = 8;
  localparam int JB_SEL   = 9;
  localparam int JB_R1    = 10;
  localparam int JB_L1    = 11;
  localparam int JB_R2    = 12;
  localparam int JB_L2    = 13;

  typedef enum logic [1:0] {
    MODE_2BTN     = 2'd0,
    MODE_4BTN     = 2'd1,
    MODE_GRAVIS   = 2'd2,
    MODE_2BTN_ALT = 2'd3
  } joy_mode_e;

  localparam int GRAV_FRAME_LEN = 24;

endpackage

// File: rtl/joystick_axis_cond.sv
// One signed 8-bit analog axis: clamp -128 to -127, then zero anything whose
// magnitude falls inside the deadzone.
module joystick_axis_cond #(
  parameter int DEADZONE = 8
) (
  input  logic [7:0] v_i,
  output logic [7:0] v_o
);

  logic [7:0] clamped;
  logic [7:0] mag;

  always_comb begin
    clamped = (v_i == 8'h80) ? 8'h81 : v_i;
    mag     = clamped[7] ? (8'd0 - clamped) : clamped;
    v_o     = (int'(mag) <= DEADZONE) ? '0 : clamped;
  end

endmodule

// File: rtl/joystick_frontend.sv
// Joystick conditioning stage: captures raw pad words on a strobe, conditions
// the analog axes, and generates the Gravis serial clock with tear-free digital updates.
module joystick_frontend
  import joystick_pkg::*;
#(
  parameter int CLK_HZ   = 90500000,
  parameter int GRAV_HZ  = 20000,
  parameter int DEADZONE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 joy_stb,
  input  logic [JOY_DIG_W-1:0] joy_dig_1,
  input  logic [JOY_DIG_W-1:0] joy_dig_2,
  input  logic [JOY_ANA_W-1:0] joy_ana_1,
  input  logic [JOY_ANA_W-1:0] joy_ana_2,
  input  logic [1:0]           mode,
  output logic [JOY_DIG_W-1:0] dig_1,
  output logic [JOY_DIG_W-1:0] dig_2,
  output logic [JOY_ANA_W-1:0] ana_1,
  output logic [JOY_ANA_W-1:0] ana_2,
  output logic                 clk_grav
);

  localparam int HALF   = CLK_HZ / (2 * GRAV_HZ);
  localparam int HCNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HALF - 1);
  localparam logic [4:0]        GPOS_MAX = 5'(GRAV_FRAME_LEN - 1);

  joy_mode_e mode_e;
  assign mode_e = joy_mode_e'(mode);

  logic [JOY_DIG_W-1:0] hold_dig_1_q, hold_dig_1_d, hold_dig_2_q, hold_dig_2_d;
  logic [JOY_ANA_W-1:0] hold_ana_1_q, hold_ana_1_d, hold_ana_2_q, hold_ana_2_d;
  logic [JOY_DIG_W-1:0] dig_1_q, dig_1_d, dig_2_q, dig_2_d;
  logic [JOY_ANA_W-1:0] ana_1_q, ana_1_d, ana_2_q, ana_2_d;
  logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
  logic                 grav_q, grav_d;
  logic [4:0]           gpos_q, gpos_d;
  logic                 grav_run, grav_rise, grav_fall, dig_load;

  joystick_axis_cond #(.DEADZONE(DEADZONE)) u_cond_x1 (.v_i(hold_ana_1_q[7:0]),  .v_o(ana_1_d[7:0]));
  joystick_axis_cond #(.DEADZONE(DEADZONE)) u_cond_y1 (.v_i(hold_ana_1_q[15:8]), .v_o(ana_1_d[15:8]));
  joystick_axis_cond #(.DEADZONE(DEADZONE)) u_cond_x2 (.v_i(hold_ana_2_q[7:0]),  .v_o(ana_2_d[7:0]));
  joystick_axis_cond #(.DEADZONE(DEADZONE)) u_cond_y2 (.v_i(hold_ana_2_q[15:8]), .v_o(ana_2_d[15:8]));

  always_comb begin
    hold_dig_1_d = joy_stb ? joy_dig_1 : hold_dig_1_q;
    hold_dig_2_d = joy_stb ? joy_dig_2 : hold_dig_2_q;
    hold_ana_1_d = joy_stb ? joy_ana_1 : hold_ana_1_q;
    hold_ana_2_d = joy_stb ? joy_ana_2 : hold_ana_2_q;

    // A high phase always runs to completion even after leaving Gravis mode.
    grav_run  = (mode_e == MODE_GRAVIS) || grav_q;
    grav_rise = 1'b0;
    grav_fall = 1'b0;
    hcnt_d    = hcnt_q;
    grav_d    = grav_q;
    gpos_d    = gpos_q;
    if (!grav_run) begin
      hcnt_d = '0;
    end else if (hcnt_q == HCNT_MAX) begin
      hcnt_d    = '0;
      grav_d    = ~grav_q;
      grav_rise = ~grav_q;
      grav_fall = grav_q;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
    if (grav_rise) begin
      gpos_d = (gpos_q == GPOS_MAX) ? '0 : gpos_q + 5'd1;
    end

    // In Gravis mode the snapshot is taken inside the frame header only.
    dig_load = (mode_e != MODE_GRAVIS) || (grav_fall && (gpos_q == 5'd1));
    dig_1_d  = dig_load ? hold_dig_1_q : dig_1_q;
    dig_2_d  = dig_load ? hold_dig_2_q : dig_2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_dig_1_q <= '0;
      hold_dig_2_q <= '0;
      hold_ana_1_q <= '0;
      hold_ana_2_q <= '0;
      dig_1_q      <= '0;
      dig_2_q      <= '0;
      ana_1_q      <= '0;
      ana_2_q      <= '0;
      hcnt_q       <= '0;
      grav_q       <= 1'b0;
      gpos_q       <= '0;
    end else begin
      hold_dig_1_q <= hold_dig_1_d;
      hold_dig_2_q <= hold_dig_2_d;
      hold_ana_1_q <= hold_ana_1_d;
      hold_ana_2_q <= hold_ana_2_d;
      dig_1_q      <= dig_1_d;
      dig_2_q      <= dig_2_d;
      ana_1_q      <= ana_1_d;
      ana_2_q      <= ana_2_d;
      hcnt_q       <= hcnt_d;
      grav_q       <= grav_d;
      gpos_q       <= gpos_d;
    end
  end

  assign dig_1    = dig_1_q;
  assign dig_2    = dig_2_q;
  assign ana_1    = ana_1_q;
  assign ana_2    = ana_2_q;
  assign clk_grav = grav_q;

endmodule

// File: tb/tb_joystick_frontend.sv
// Randomized bench for joystick_frontend against a cycle-level behavioural
// reference and a serial-consumer model that tracks frame position and tearing.
module tb_joystick_frontend;

  localparam int CLK_HZ   = 1400;
  localparam int GRAV_HZ  = 100;
  localparam int DEADZONE = 8;
  localparam int HALF     = CLK_HZ / (2 * GRAV_HZ);
  localparam int FRAME    = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        joy_stb = 1'b0;
  logic [13:0] joy_dig_1 = '0, joy_dig_2 = '0;
  logic [15:0] joy_ana_1 = '0, joy_ana_2 = '0;
  logic [1:0]  mode = 2'd0;
  logic [13:0] dig_1, dig_2;
  logic [15:0] ana_1, ana_2;
  logic        clk_grav;

  joystick_frontend #(
    .CLK_HZ  (CLK_HZ),
    .GRAV_HZ (GRAV_HZ),
    .DEADZONE(DEADZONE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .joy_stb  (joy_stb),
    .joy_dig_1(joy_dig_1),
    .joy_dig_2(joy_dig_2),
    .joy_ana_1(joy_ana_1),
    .joy_ana_2(joy_ana_2),
    .mode     (mode),
    .dig_1    (dig_1),
    .dig_2    (dig_2),
    .ana_1    (ana_1),
    .ana_2    (ana_2),
    .clk_grav (clk_grav)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state
  logic [13:0] m_hold_dig1 = '0, m_hold_dig2 = '0, e_dig1 = '0, e_dig2 = '0;
  logic [15:0] m_hold_ana1 = '0, m_hold_ana2 = '0, e_ana1 = '0, e_ana2 = '0;
  bit          m_grav = 1'b0;
  int          m_left = HALF;
  int          m_pos  = 0;

  // Consumer model, driven only by observed clk_grav edges
  bit          prev_cg = 1'b0;
  int          cons_pos = 0;
  bit          fvalid = 1'b0;
  logic [13:0] fsnap = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] cond_axis(input logic [7:0] b);
    int v;
    int mag;
    v = $signed(b);
    if (v == -128) v = -127;
    mag = (v < 0) ? -v : v;
    if (mag <= DEADZONE) v = 0;
    return 8'(v);
  endfunction

  function automatic logic [15:0] cond_word(input logic [15:0] w);
    return {cond_axis(w[15:8]), cond_axis(w[7:0])};
  endfunction

  function automatic logic [7:0] rand_axis();
    logic [7:0] edges [8];
    edges = '{8'h80, 8'h81, 8'hF7, 8'hF8, 8'h08, 8'h09, 8'h00, 8'h7F};
    if ($urandom_range(1) == 0) return edges[$urandom_range(7)];
    return 8'($urandom);
  endfunction

  // One clock: advance reference on the edge, then compare 1 time unit later.
  task automatic step();
    bit fall;
    int old_pos;
    @(posedge clk);
    if (rst) begin
      m_hold_dig1 = '0; m_hold_dig2 = '0; m_hold_ana1 = '0; m_hold_ana2 = '0;
      e_dig1 = '0; e_dig2 = '0; e_ana1 = '0; e_ana2 = '0;
      m_grav = 1'b0; m_left = HALF; m_pos = 0;
    end else begin
      fall    = 1'b0;
      old_pos = m_pos;
      if (mode == 2'd2 || m_grav) begin
        m_left--;
        if (m_left == 0) begin
          m_left = HALF;
          if (m_grav) fall = 1'b1;
          else m_pos = (m_pos + 1) % FRAME;
          m_grav = !m_grav;
        end
      end else begin
        m_left = HALF;
      end
      if (mode != 2'd2 || (fall && old_pos == 1)) begin
        e_dig1 = m_hold_dig1;
        e_dig2 = m_hold_dig2;
      end
      e_ana1 = cond_word(m_hold_ana1);
      e_ana2 = cond_word(m_hold_ana2);
      if (joy_stb) begin
        m_hold_dig1 = joy_dig_1; m_hold_dig2 = joy_dig_2;
        m_hold_ana1 = joy_ana_1; m_hold_ana2 = joy_ana_2;
      end
    end
    #1;
    check("dig_1", 32'(dig_1), 32'(e_dig1));
    check("dig_2", 32'(dig_2), 32'(e_dig2));
    check("ana_1", 32'(ana_1), 32'(e_ana1));
    check("ana_2", 32'(ana_2), 32'(e_ana2));
    check("clk_grav", 32'(clk_grav), 32'(m_grav));

    if (rst) begin
      cons_pos = 0; prev_cg = 1'b0; fvalid = 1'b0;
    end else begin
      if (mode != 2'd2) fvalid = 1'b0;
      if (!prev_cg && clk_grav) begin
        cons_pos = (cons_pos + 1) % FRAME;
        check("grav_pos", 32'(cons_pos), 32'(m_pos));
        if (mode == 2'd2 && cons_pos == 2) begin
          fsnap = dig_1; fvalid = 1'b1;
        end else if (fvalid && cons_pos > 2) begin
          check("torn_frame", 32'(dig_1), 32'(fsnap));
        end
      end
      prev_cg = clk_grav;
    end
  endtask

  task automatic wait_toggle(output int n);
    bit start;
    start = clk_grav;
    n = 0;
    do begin
      step();
      n++;
    end while (clk_grav == start && n < 4 * HALF);
  endtask

  task automatic randomize_inputs(input int stb_pct);
    joy_stb   = ($urandom_range(99) < stb_pct);
    joy_dig_1 = 14'($urandom);
    joy_dig_2 = 14'($urandom);
    joy_ana_1 = {rand_axis(), rand_axis()};
    joy_ana_2 = {rand_axis(), rand_axis()};
  endtask

  initial begin
    int n;
    int guard;

    // Reset and 2-clock digital latency
    rst = 1'b1; step(); step();
    check("rst_dig_1", 32'(dig_1), 32'h0);
    check("rst_clk_grav", 32'(clk_grav), 32'h0);
    rst = 1'b0; mode = 2'd0;
    joy_stb = 1'b1; joy_dig_1 = 14'h0010; step();
    joy_stb = 1'b0; joy_dig_1 = 14'h3FFF; step();
    check("dig_latency", 32'(dig_1), 32'h0010);

    // Clamp and deadzone
    joy_stb = 1'b1; joy_ana_1 = 16'h8005; step();
    joy_stb = 1'b0; step();
    check("ana_clamp_dz", 32'(ana_1), 32'h8100);
    joy_stb = 1'b1; joy_ana_1 = 16'h09F7; step();
    joy_stb = 1'b0; step();
    check("ana_pass", 32'(ana_1), 32'h09F7);

    // Random non-Gravis traffic
    for (int i = 0; i < 300; i++) begin
      mode = 2'($urandom_range(3));
      if (mode == 2'd2) mode = 2'd3;
      randomize_inputs(25);
      step();
    end
    check("idle_clk_grav", 32'(clk_grav), 32'h0);

    // Gravis entry timing and period
    joy_stb = 1'b0; mode = 2'd2;
    wait_toggle(n); check("first_rise", 32'(n), 32'(HALF));
    wait_toggle(n); check("low_phase", 32'(n), 32'(HALF));
    wait_toggle(n); check("high_phase", 32'(n), 32'(HALF));

    // New data mid-frame must not appear before the header
    guard = 0;
    while (cons_pos != 12 && guard < 4 * FRAME * HALF) begin step(); guard++; end
    check("reach_pos12", 32'(cons_pos), 32'd12);
    joy_stb = 1'b1; joy_dig_1 = 14'h2A55; step();
    joy_stb = 1'b0;
    for (int i = 0; i < 3 * FRAME * HALF; i++) step();
    check("dig_after_frame", 32'(dig_1), 32'h2A55);

    // Leave Gravis while high: high phase completes, then stays low
    guard = 0;
    while (!(clk_grav && m_left == HALF) && guard < 4 * HALF) begin step(); guard++; end
    step();
    mode = 2'd0;
    wait_toggle(n); check("high_completes", 32'(n + 1), 32'(HALF));
    for (int i = 0; i < 5 * HALF; i++) step();
    check("held_low", 32'(clk_grav), 32'h0);
    mode = 2'd2;
    wait_toggle(n); check("reentry_rise", 32'(n), 32'(HALF));

    // Reset mid-frame
    guard = 0;
    while (cons_pos != 15 && guard < 4 * FRAME * HALF) begin step(); guard++; end
    check("reach_pos15", 32'(cons_pos), 32'd15);
    rst = 1'b1; step();
    check("midrst_dig_1", 32'(dig_1), 32'h0);
    check("midrst_ana_1", 32'(ana_1), 32'h0);
    rst = 1'b0;
    wait_toggle(n); check("rst_first_rise", 32'(n), 32'(HALF));

    // Random mix with mode changes and rare resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(59) == 0) mode = ($urandom_range(1) == 0) ? 2'd2 : 2'($urandom_range(3));
      rst = ($urandom_range(1499) == 0);
      randomize_inputs(12);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
